hw_loop_ctrl: RTL

//  Zero-overhead hardware loop sequencer for the picoMIPS fetch path; drives the PC's loop-target inputs.

---
 rtl/picomips_pkg.sv | 19 +
 rtl/hw_loop_entry.sv | 64 ++++++
 rtl/hw_loop_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMIPS fetch path: address/count widths,
// the loop descriptor record and the halt address.
package picomips_pkg;

    localparam int PSIZE = 6;
    localparam int CSIZE = 8;

    localparam logic [PSIZE-1:0] HALT_ADDR = 6'd63;

    // One hardware loop descriptor as held by a loop entry.
    typedef struct packed {
        logic [PSIZE-1:0] start_addr;
        logic [PSIZE-1:0] end_addr;
        logic [CSIZE-1:0] count;
        logic [CSIZE-1:0] remaining;
        logic             armed;
    } loop_desc_t;

endpackage

// File: rtl/hw_loop_entry.sv
// One hardware loop descriptor: stores start/end/count, compares the PC
// against the end address and tracks the remaining iterations.
module hw_loop_entry
    import picomips_pkg::*;
#(
    parameter int Psize = PSIZE,
    parameter int Csize = CSIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Psize-1:0] pc,
    input  logic             wr,
    input  logic [Psize-1:0] wr_start,
    input  logic [Psize-1:0] wr_end,
    input  logic [Csize-1:0] wr_count,
    input  logic             advance,
    output logic             match,
    output logic             last,
    output logic [Psize-1:0] start_addr,
    output logic [Psize-1:0] end_addr,
    output logic             armed
);

    localparam logic [Csize-1:0] ONE = Csize'(1);

    logic [Csize-1:0] count_q;
    logic [Csize-1:0] rem_q;

    // Descriptor storage; a write to this entry takes precedence over the
    // iteration update so a reprogrammed loop always starts from its new count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_addr <= '0;
            end_addr   <= '0;
            count_q    <= '0;
            rem_q      <= '0;
            armed      <= 1'b0;
        end else if (wr) begin
            if (wr_count == '0) begin
                armed <= 1'b0;
            end else if (wr_start <= wr_end) begin
                start_addr <= wr_start;
                end_addr   <= wr_end;
                count_q    <= wr_count;
                rem_q      <= wr_count;
                armed      <= 1'b1;
            end
        end else if (advance) begin
            // On the final pass reload so an enclosing loop can rerun this one.
            if (rem_q > ONE) begin
                rem_q <= rem_q - ONE;
            end else begin
                rem_q <= count_q;
            end
        end
    end

    // End-address compare and last-iteration flag.
    always_comb begin
        match = armed && (pc == end_addr);
        last  = (rem_q == ONE);
    end

endmodule

// File: rtl/hw_loop_ctrl.sv
// Zero-overhead hardware loop sequencer. NLOOP descriptors are compared
// against the current PC; the lowest-index matching entry supplies the
// next-PC override (loop start while iterating, end+1 on exit).
module hw_loop_ctrl
    import picomips_pkg::*;
#(
    parameter int Psize = PSIZE,
    parameter int NLOOP = 4,
    parameter int Csize = CSIZE,
    localparam int IW   = (NLOOP > 1) ? $clog2(NLOOP) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Psize-1:0] PCout,
    input  logic             PCvalid,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [Psize-1:0] cfg_start,
    input  logic [Psize-1:0] cfg_end,
    input  logic [Csize-1:0] cfg_count,
    output logic             loop_taken,
    output logic [Psize-1:0] loop_target,
    output logic [NLOOP-1:0] loop_armed,
    output logic             cfg_err
);

    logic [NLOOP-1:0] match;
    logic [NLOOP-1:0] last;
    logic [NLOOP-1:0] grant;
    logic [NLOOP-1:0] advance;
    logic [Psize-1:0] starts [NLOOP];
    logic [Psize-1:0] ends   [NLOOP];

    for (genvar g = 0; g < NLOOP; g++) begin : g_entry
        // A stall holds the PC, so the winning entry only advances when it moves.
        assign advance[g] = PCvalid & grant[g];

        hw_loop_entry #(
            .Psize (Psize),
            .Csize (Csize)
        ) u_entry (
            .clk        (clk),
            .reset      (reset),
            .pc         (PCout),
            .wr         (cfg_we && (cfg_idx == IW'(g))),
            .wr_start   (cfg_start),
            .wr_end     (cfg_end),
            .wr_count   (cfg_count),
            .advance    (advance[g]),
            .match      (match[g]),
            .last       (last[g]),
            .start_addr (starts[g]),
            .end_addr   (ends[g]),
            .armed      (loop_armed[g])
        );
    end

    // Priority encode: scan from the outermost entry down so the innermost
    // (lowest index) match overwrites any other.
    always_comb begin
        grant       = '0;
        loop_taken  = 1'b0;
        loop_target = '0;
        for (int i = NLOOP - 1; i >= 0; i--) begin
            if (match[i]) begin
                grant       = '0;
                grant[i]    = 1'b1;
                loop_taken  = 1'b1;
                loop_target = last[i] ? (ends[i] + Psize'(1)) : starts[i];
            end
        end
    end

    // Rejected-write flag, visible for the single cycle after the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && (cfg_count != '0) && (cfg_start > cfg_end);
        end
    end

endmodule
